// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-memory bridge.
// Holds the command/response byte values of the host protocol, the FSM state
// encoding and a small helper that classifies command bytes.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_MEM   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Byte-FIFO and memory-bus signals between the bridge and its surroundings.
//   receivable/recv_data/recv_flag : receive FIFO head and pop strobe
//   sendable/send_data/send_flag   : send FIFO space and push strobe
//   mem_*                          : single-word request/ready memory bus
// master is the bridge side, slave is the FIFO/memory side.
interface uart_mem_bridge_if;

  logic        receivable;
  logic [7:0]  recv_data;
  logic        recv_flag;
  logic        sendable;
  logic [7:0]  send_data;
  logic        send_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  receivable, recv_data, sendable, mem_rdata, mem_ready,
    output recv_flag, send_data, send_flag, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output receivable, recv_data, sendable, mem_rdata, mem_ready,
    input  recv_flag, send_data, send_flag, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/uart_mem_bridge.sv
// Command-frame responder behind a buffered UART byte interface.
// Parses write (57 a0..a3 d0..d3) and read (52 a0..a3) frames from the receive
// FIFO, performs one memory access, and returns ACK or four read-data bytes
// (LSB first) through the send FIFO. Unknown command bytes get a NAK.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   bus          : FIFO + memory signals (uart_mem_bridge_if.master)
//   busy         : high whenever the FSM is not idle
//   err_timeout  : sticky, set when a frame stalls too long mid-way
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic              CLK,
  input  logic              RST,
  uart_mem_bridge_if.master bus,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [1:0]      rcnt_q, rcnt_d;
  logic [1:0]      rlast_q, rlast_d;
  logic            is_write_q, is_write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     resp_q, resp_d;
  logic [CntW-1:0] idle_q, idle_d;
  logic            err_q, err_d;
  logic            pop_block_q, push_block_q;
  logic            pop, push, timeout, in_frame;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Output decode
  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_re  = 1'b0;
    unique case (state_q)
      S_IDLE, S_ADDR, S_WDATA: pop = bus.receivable && !pop_block_q;
      S_MEM: begin
        bus.mem_we = is_write_q;
        bus.mem_re = !is_write_q;
      end
      S_RESP:  push = bus.sendable && !push_block_q;
      default: ;
    endcase
  end

  assign in_frame      = (state_q == S_ADDR) || (state_q == S_WDATA);
  assign timeout       = in_frame && !pop && (idle_q == CntMax);
  assign bus.recv_flag = pop;
  assign bus.send_flag = push;
  assign bus.send_data = resp_q[{rcnt_q, 3'b000} +: 8];
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign err_timeout   = err_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pop) state_d = is_cmd(bus.recv_data) ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (pop && bcnt_q == 2'd3) state_d = is_write_q ? S_WDATA : S_MEM;
        else if (timeout)          state_d = S_IDLE;
      end
      S_WDATA: begin
        if (pop && bcnt_q == 2'd3) state_d = S_MEM;
        else if (timeout)          state_d = S_IDLE;
      end
      S_MEM:   if (bus.mem_ready) state_d = S_RESP;
      S_RESP:  if (push && rcnt_q == rlast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte assembler / response serializer
  always_comb begin
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    rlast_d    = rlast_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    err_d      = err_q;
    idle_d     = '0;
    if (in_frame && !pop && !timeout) idle_d = idle_q + CntW'(1);
    if (timeout) err_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          bcnt_d = 2'd0;
          rcnt_d = 2'd0;
          if (is_cmd(bus.recv_data)) begin
            is_write_d = (bus.recv_data == CMD_WRITE);
            err_d      = 1'b0;
          end else begin
            resp_d  = {24'h0, RSP_NAK};
            rlast_d = 2'd0;
          end
        end
      end
      S_ADDR: begin
        if (pop) begin
          addr_d[{bcnt_q, 3'b000} +: 8] = bus.recv_data;
          bcnt_d = bcnt_q + 2'd1;
        end
      end
      S_WDATA: begin
        if (pop) begin
          wdata_d[{bcnt_q, 3'b000} +: 8] = bus.recv_data;
          bcnt_d = bcnt_q + 2'd1;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          resp_d  = is_write_q ? {24'h0, RSP_ACK} : bus.mem_rdata;
          rlast_d = is_write_q ? 2'd0 : 2'd3;
          rcnt_d  = 2'd0;
        end
      end
      S_RESP:  if (push) rcnt_d = rcnt_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt_q       <= '0;
      rcnt_q       <= '0;
      rlast_q      <= '0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      idle_q       <= '0;
      err_q        <= 1'b0;
      // Held high in reset so both strobes stay low while RST is asserted and
      // the FIFO flags are still settling; they clear on the first clock after.
      pop_block_q  <= 1'b1;
      push_block_q <= 1'b1;
    end else begin
      bcnt_q       <= bcnt_d;
      rcnt_q       <= rcnt_d;
      rlast_q      <= rlast_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
      // FIFO flags lag a pop/push by one cycle, so skip the cycle after each.
      pop_block_q  <= pop;
      push_block_q <= push;
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
module tb_uart_mem_bridge;

  localparam int unsigned TOUT = 40;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mop_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic busy, err_timeout;

  uart_mem_bridge_if bus ();

  uart_mem_bridge #(.TIMEOUT_CYCLES(TOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rxq[$];
  logic [7:0] cur[$];
  logic [7:0] exp_tx[$];
  logic [7:0] txlog[$];
  mop_t       exp_mem[$];
  mop_t       memlog[$];

  int checks = 0;
  int errors = 0;
  int we_cyc = 0;
  int re_cyc = 0;
  int mem_lat = 1;
  int mcnt = 0;

  logic pop_s = 1'b0, req_s = 1'b0;
  logic prev_pop = 1'b0, prev_push = 1'b0, prev_req = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  mop_t mon_m, mon_e;
  logic [7:0] mon_b;

  // Receive FIFO model: flags shown to the DUT lag each pop by one cycle.
  always @(posedge CLK) begin
    if (RST) begin
      bus.receivable <= 1'b0;
      bus.recv_data  <= 8'h00;
    end else begin
      bus.receivable <= (rxq.size() > 0);
      bus.recv_data  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
      if (pop_s && rxq.size() > 0) void'(rxq.pop_front());
    end
  end

  // Memory model: ready arrives mem_lat cycles after the request appears.
  always @(posedge CLK) begin
    if (RST) begin
      mcnt = 0;
      bus.mem_ready <= 1'b0;
    end else if (req_s) begin
      if (bus.mem_ready) begin
        mcnt = 0;
        bus.mem_ready <= 1'b0;
      end else begin
        mcnt = mcnt + 1;
        bus.mem_ready <= (mcnt >= mem_lat);
      end
    end else begin
      mcnt = 0;
      bus.mem_ready <= 1'b0;
    end
  end

  // Compare process: sampled mid-cycle.
  always @(negedge CLK) begin
    pop_s = bus.recv_flag;
    req_s = bus.mem_we | bus.mem_re;
    if (!RST) begin
      if (bus.recv_flag) begin
        checks++;
        if (!bus.receivable || prev_pop) begin
          errors++;
          $display("FAIL pop_rule receivable=%0b prev_pop=%0b required 1/0", bus.receivable,
                   prev_pop);
        end
      end
      if (bus.send_flag) begin
        checks++;
        if (!bus.sendable || prev_push) begin
          errors++;
          $display("FAIL push_rule sendable=%0b prev_push=%0b required 1/0", bus.sendable,
                   prev_push);
        end
      end
      if (req_s) begin
        checks++;
        if (bus.mem_we && bus.mem_re) begin
          errors++;
          $display("FAIL mem_excl we=1 re=1 required not both");
        end else if (prev_req && (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata ||
                                  bus.mem_we !== prev_we)) begin
          errors++;
          $display("FAIL mem_hold addr=%h wdata=%h required addr=%h wdata=%h", bus.mem_addr,
                   bus.mem_wdata, prev_addr, prev_wdata);
        end
      end
      if (bus.mem_we) we_cyc++;
      if (bus.mem_re) re_cyc++;
      if (bus.send_flag && bus.sendable) begin
        txlog.push_back(bus.send_data);
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_byte got=%h required none", bus.send_data);
        end else begin
          mon_b = exp_tx.pop_front();
          if (bus.send_data !== mon_b) begin
            errors++;
            $display("FAIL tx_byte got=%h required %h", bus.send_data, mon_b);
          end
        end
      end
      if (req_s && bus.mem_ready) begin
        mon_m.we    = bus.mem_we;
        mon_m.addr  = bus.mem_addr;
        mon_m.wdata = bus.mem_wdata;
        memlog.push_back(mon_m);
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_op got we=%0b addr=%h required none", mon_m.we, mon_m.addr);
        end else begin
          mon_e = exp_mem.pop_front();
          if (mon_m.we !== mon_e.we || mon_m.addr !== mon_e.addr ||
              (mon_e.we && mon_m.wdata !== mon_e.wdata)) begin
            errors++;
            $display("FAIL mem_op got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                     mon_m.we, mon_m.addr, mon_m.wdata, mon_e.we, mon_e.addr, mon_e.wdata);
          end
        end
      end
    end
    prev_pop   = bus.recv_flag;
    prev_push  = bus.send_flag;
    prev_req   = req_s;
    prev_we    = bus.mem_we;
    prev_addr  = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (txlog.size() > i) ? {24'h0, txlog[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    return (memlog.size() > i) ? memlog[i].addr : 32'hFFFF_FFFF;
  endfunction

  // Frame bytes listed first-to-last from the top of v.
  task automatic build(input logic [71:0] v, input int n);
    cur.delete();
    for (int k = 0; k < n; k++) cur.push_back(v[8*(n-1-k) +: 8]);
  endtask

  function automatic logic [31:0] le32(input int p);
    return {cur[p+3], cur[p+2], cur[p+1], cur[p]};
  endfunction

  // Protocol-level model: bytes in, expected memory ops and reply bytes out.
  task automatic model_frame(input logic [31:0] rd);
    int i;
    mop_t m;
    i = 0;
    while (i < cur.size()) begin
      if (cur[i] == 8'h57 && i + 9 <= cur.size()) begin
        m.we = 1'b1; m.addr = le32(i + 1); m.wdata = le32(i + 5);
        exp_mem.push_back(m);
        exp_tx.push_back(8'h06);
        i += 9;
      end else if (cur[i] == 8'h52 && i + 5 <= cur.size()) begin
        m.we = 1'b0; m.addr = le32(i + 1); m.wdata = '0;
        exp_mem.push_back(m);
        for (int k = 0; k < 4; k++) exp_tx.push_back(rd[8*k +: 8]);
        i += 5;
      end else if (cur[i] == 8'h57 || cur[i] == 8'h52) begin
        break;  // truncated frame is aborted: no access, no reply
      end else begin
        exp_tx.push_back(8'h15);
        i += 1;
      end
    end
  endtask

  task automatic start(input int lat, input logic [31:0] rd);
    txlog.delete();
    memlog.delete();
    we_cyc  = 0;
    re_cyc  = 0;
    mem_lat = lat;
    bus.mem_rdata = rd;
    model_frame(rd);
    foreach (cur[i]) rxq.push_back(cur[i]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 2000 && !(rxq.size() == 0 && !bus.receivable && !busy && exp_tx.size() == 0 &&
                         exp_mem.size() == 0)) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_done busy=%0b pending_tx=%0d pending_mem=%0d required 0/0/0", name,
               busy, exp_tx.size(), exp_mem.size());
    end
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while (n < 500 && (rxq.size() != 0 || bus.receivable)) begin
      cyc();
      n++;
    end
    chk({name, "_drained"}, rxq.size(), 0);
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_timeout, 0);
    chk({p, "_recv_flag"}, bus.recv_flag, 0);
    chk({p, "_send_flag"}, bus.send_flag, 0);
    chk({p, "_send_data"}, bus.send_data, 0);
    chk({p, "_we"}, bus.mem_we, 0);
    chk({p, "_re"}, bus.mem_re, 0);
    chk({p, "_addr"}, bus.mem_addr, 0);
    chk({p, "_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.sendable  = 1'b1;
    bus.mem_rdata = '0;
    RST = 1'b1;
    cyc(3);
    chk_all_zero("rst");
    RST = 1'b0;
    cyc(2);

    // Write frame, ready one cycle after request
    build(72'h57_10000000_EFBEADDE, 9);
    start(1, 32'h0);
    wait_done("write");
    chk("wr_addr", addr_at(0), 32'h0000_0010);
    chk("wr_data", (memlog.size() > 0) ? memlog[0].wdata : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    chk("wr_we_cycles", we_cyc, 2);
    chk("wr_re_cycles", re_cyc, 0);
    chk("wr_tx_count", txlog.size(), 1);
    chk("wr_ack", tx_at(0), 32'h06);
    chk("wr_busy", busy, 0);

    // Read frame, ready delayed 5 cycles
    build(72'h52_20000000, 5);
    start(5, 32'h1234_5678);
    wait_done("read");
    chk("rd_re_cycles", re_cyc, 6);
    chk("rd_we_cycles", we_cyc, 0);
    chk("rd_addr", addr_at(0), 32'h0000_0020);
    chk("rd_b0", tx_at(0), 32'h78);
    chk("rd_b1", tx_at(1), 32'h56);
    chk("rd_b2", tx_at(2), 32'h34);
    chk("rd_b3", tx_at(3), 32'h12);

    // Unknown command then a read
    build(72'h41_52_04000000, 6);
    start(1, 32'hA5A5_0001);
    wait_done("badcmd");
    chk("bad_nak", tx_at(0), 32'h15);
    chk("bad_tx_count", txlog.size(), 5);
    chk("bad_rd_addr", addr_at(0), 32'h0000_0004);
    chk("bad_rd_b0", tx_at(1), 32'h01);

    // Timeout mid-frame
    build(72'h57_1000, 3);
    start(1, 32'h0);
    wait_drained("to");
    cyc(TOUT + 20);
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_we_cycles", we_cyc, 0);
    chk("to_tx_count", txlog.size(), 0);
    build(72'h52_08000000, 5);
    start(2, 32'h0102_0304);
    n = 0;
    while (!busy && n < 50) begin
      cyc();
      n++;
    end
    chk("to_next_busy", busy, 1);
    chk("to_err_cleared", err_timeout, 0);
    wait_done("to_read");
    chk("to_rd_addr", addr_at(0), 32'h0000_0008);
    chk("to_rd_b3", tx_at(3), 32'h01);

    // Backpressure during read response
    build(72'h52_30000000, 5);
    start(2, 32'hCAFE_F00D);
    n = 0;
    while (txlog.size() < 1 && n < 200) begin
      cyc();
      n++;
    end
    bus.sendable = 1'b0;
    cyc(20);
    chk("bp_stall", txlog.size(), 1);
    bus.sendable = 1'b1;
    wait_done("bp");
    chk("bp_b0", tx_at(0), 32'h0D);
    chk("bp_b1", tx_at(1), 32'hF0);
    chk("bp_b2", tx_at(2), 32'hFE);
    chk("bp_b3", tx_at(3), 32'hCA);

    // Reset mid-frame
    build(72'h57_1000, 3);
    start(1, 32'h0);
    wait_drained("mf");
    chk("mf_busy_pre", busy, 1);
    chk("mf_addr_pre", bus.mem_addr, 32'h0000_0010);
    RST = 1'b1;
    #1;
    chk_all_zero("mf");
    rxq.delete();
    exp_tx.delete();
    exp_mem.delete();
    cyc(3);
    RST = 1'b0;
    cyc(2);
    build(72'h52_40000000, 5);
    start(1, 32'h0BAD_F00D);
    wait_done("mf_read");
    chk("mf_rd_addr", addr_at(0), 32'h0000_0040);
    chk("mf_tx_count", txlog.size(), 4);
    chk("mf_b0", tx_at(0), 32'h0D);
    chk("mf_b3", tx_at(3), 32'h0B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Byte-stream responder at the far side of uart_comm's buffered byte interface.
- Consumes command frames from uart_comm's receive FIFO and issues single-word reads and writes on a simple memory bus.
- Returns response bytes through uart_comm's send FIFO.
- Gives a host PC debug/load access to the memory subsystem over the UART link.

Parameters:
TIMEOUT_CYCLES, 5000000, max idle cycles between bytes of one frame before the frame is aborted (100 ms at 50 MHz)

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
receivable  input  1  uart_comm receive FIFO non-empty
recv_data  input  8  receive FIFO head byte (first-word-fall-through; valid while receivable)
recv_flag  output  1  one-cycle pop of receive FIFO
sendable  input  1  uart_comm send FIFO not full
send_data  output  8  byte to enqueue
send_flag  output  1  one-cycle push to send FIFO
mem_addr  output  32  word address
mem_wdata  output  32  write data
mem_we  output  1  write request, held until mem_ready
mem_re  output  1  read request, held until mem_ready
mem_rdata  input  32  read data, valid in the mem_ready cycle
mem_ready  input  1  request completes this cycle
busy  output  1  high whenever state != S_IDLE
err_timeout  output  1  sticky frame-timeout flag; cleared on next accepted command byte

Behaviour:
Reset values:
- All outputs 0; state S_IDLE; counters 0.
- RST mid-frame discards the partial frame and drops any mem request immediately.

Frame format:
- Write: cmd 0x57, addr[4 bytes LE], data[4 bytes LE].
- Read: cmd 0x52, addr[4 bytes LE].
- Response to write: single byte 0x06 (ACK), sent after mem_ready.
- Response to read: mem_rdata as 4 bytes, LSB first.
- Any other cmd byte: respond 0x15 (NAK); return to S_IDLE; following bytes are parsed as new commands.

FIFO handshake:
- recv_flag pulses only when receivable=1. recv_data is sampled in the same cycle.
- At most one pop per 2 cycles; FIFO flags update one cycle after a pop.
- send_flag pulses only when sendable=1, with send_data valid in the same cycle. Same one-push-per-2-cycles rule.
- While sendable=0, the response stalls; no byte is dropped or reordered.

States:
- S_IDLE: pop cmd byte.
  - 0x57 or 0x52: clear err_timeout, bcnt=0, go to S_ADDR.
  - Otherwise: load NAK, go to S_RESP with rcnt=0.
- S_ADDR: pop 4 bytes into mem_addr[8*bcnt+:8].
  - After bcnt==3: write goes to S_WDATA (bcnt=0); read goes to S_MEM.
- S_WDATA: pop 4 bytes into mem_wdata the same way; then S_MEM.
- S_MEM: assert mem_we or mem_re on entry; mem_addr and mem_wdata held stable.
  - On mem_ready: deassert in the next cycle; latch mem_rdata into the response register; go to S_RESP.
  - No timeout in S_MEM.
- S_RESP: push response bytes.
  - Length is 1 for ACK/NAK, 4 for read data; rcnt counts pushes.
  - After the last push: S_IDLE.

Timeout:
- Idle counter runs in S_ADDR and S_WDATA. It resets on every pop.
- On reaching TIMEOUT_CYCLES-1: set err_timeout and go to S_IDLE. No mem access and no response.

Other rules:
- mem_we and mem_re are never both high.
- mem_ready outside S_MEM is ignored.
- Simultaneous receivable and pending response: response completes first; no pop occurs in S_RESP or S_MEM.
- Byte counters are 2-bit and wrap naturally. The state transition happens on the count-3 pop.

Decomposition:
- Shared package uart_bridge_pkg:
  - Command and response constants: CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15.
  - State encoding constants.
- No sub-module. A single FSM with a byte assembler/serializer is natural, ~200 lines.
- Bench instantiates uart_comm-compatible FIFO models, or uart_comm itself with a serial host model for the integration test.

Test Plan:
- Write frame: push 57 10 00 00 00 EF BE AD DE; mem_ready after 1 cycle.
  - Required: mem_we=1 with mem_addr=0x00000010 and mem_wdata=0xDEADBEEF held until ready.
  - Then exactly one send byte 0x06; busy returns to 0.
- Read frame: push 52 20 00 00 00; mem_rdata=0x12345678 with mem_ready delayed 5 cycles.
  - Required: mem_re held stable for 6 cycles; mem_we stays 0.
  - Sends 78 56 34 12 in order.
- Bad command: push 41 then 52 04 00 00 00.
  - Required: sends 15, then performs read at 0x00000004.
- Timeout: push 57 10 00, then stall TIMEOUT_CYCLES cycles.
  - Required: err_timeout=1, state S_IDLE, no mem_we.
  - Next valid 52 frame clears err_timeout and completes normally.
- Backpressure: during a read response, hold sendable=0 for 20 cycles after the first byte.
  - Required: no send_flag while low; remaining 3 bytes are then sent in correct order.
- Reset mid-frame: assert RST after 57 10 00.
  - Required: all outputs 0 immediately.
  - After release, a fresh 52 frame succeeds; stale bytes are not merged.
